// File: rtl/fdivsqrt_r2_ctrl.sv
// Sequencing controller for the radix-2 unified divide/square-root datapath.
// Accepts an operation, steps the iteration datapath a format-dependent number of times, then holds the result handshake.
module fdivsqrt_r2_ctrl #(
  parameter int CNTW    = 7,
  parameter int ITERS_H = 13,
  parameter int ITERS_S = 26,
  parameter int ITERS_D = 55,
  parameter int ITERS_Q = 115
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic            sqrt,
  input  logic [1:0]      fmt,
  input  logic            special_case,
  input  logic            flush,
  input  logic            wzero,
  input  logic            up,
  input  logic            uz,
  input  logic            un,
  output logic            load,
  output logic            iter_en,
  output logic            first_iter,
  output logic            sqrt_op,
  output logic [CNTW-1:0] iter_cnt,
  output logic            busy,
  output logic            done_valid,
  input  logic            done_ready,
  output logic            early_term,
  output logic            digit_err
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t     state_q;
  state_t     state_d;
  logic       accept;
  logic       early_stop;
  logic [1:0] digit_sum;

  function automatic logic [CNTW-1:0] iters_for(input logic [1:0] f);
    case (f)
      2'b00:   return CNTW'(ITERS_S);
      2'b01:   return CNTW'(ITERS_D);
      2'b10:   return CNTW'(ITERS_H);
      default: return CNTW'(ITERS_Q);
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Zero-residual exit is not trusted in the first cycle: the residual is only just loaded.
  always_comb begin
    start_ready = (state_q == IDLE) & ~flush;
    accept      = start_valid & start_ready;
    early_stop  = (state_q == BUSY) & ~flush & wzero & ~first_iter;
    load        = accept;
    busy        = (state_q != IDLE);
    done_valid  = (state_q == DONE) & ~flush;
    iter_en     = (state_q == BUSY) & ~flush & ~early_stop & (iter_cnt != '0);
    digit_sum   = 2'(up) + 2'(uz) + 2'(un);
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (accept) state_d = special_case ? DONE : BUSY;
        BUSY: if (early_stop || iter_cnt <= CNTW'(1)) state_d = DONE;
        DONE: if (done_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      iter_cnt   <= '0;
      sqrt_op    <= 1'b0;
      early_term <= 1'b0;
      digit_err  <= 1'b0;
      first_iter <= 1'b0;
    end else begin
      first_iter <= accept & ~special_case;
      if (accept) begin
        iter_cnt   <= iters_for(fmt);
        sqrt_op    <= sqrt;
        early_term <= 1'b0;
        digit_err  <= 1'b0;
      end else begin
        if (iter_en) iter_cnt <= iter_cnt - CNTW'(1);
        if (early_stop) early_term <= 1'b1;
        if (iter_en && digit_sum != 2'd1) digit_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fdivsqrt_r2_ctrl.sv
// Directed bench for fdivsqrt_r2_ctrl: handshake timing, iteration counts, early exit, flush, reset and digit check.
module tb_fdivsqrt_r2_ctrl;
  logic       clk = 1'b0;
  logic       reset_n, start_valid, start_ready, sqrt, special_case, flush, wzero;
  logic [1:0] fmt;
  logic       up, uz, un, load, iter_en, first_iter, sqrt_op, busy;
  logic       done_valid, done_ready, early_term, digit_err;
  logic [6:0] iter_cnt;

  int passed = 0;
  int total  = 0;

  fdivsqrt_r2_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start_valid(start_valid), .start_ready(start_ready),
    .sqrt(sqrt), .fmt(fmt), .special_case(special_case), .flush(flush), .wzero(wzero),
    .up(up), .uz(uz), .un(un), .load(load), .iter_en(iter_en), .first_iter(first_iter),
    .sqrt_op(sqrt_op), .iter_cnt(iter_cnt), .busy(busy), .done_valid(done_valid),
    .done_ready(done_ready), .early_term(early_term), .digit_err(digit_err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    int  n_it, lat;
    bit  got;

    reset_n = 1'b0; start_valid = 1'b0; sqrt = 1'b0; fmt = 2'b00; special_case = 1'b0;
    flush = 1'b0; wzero = 1'b0; up = 1'b1; uz = 1'b0; un = 1'b0; done_ready = 1'b0;

    // reset state
    mid();
    chk("rst_busy", busy, 0);       chk("rst_start_ready", start_ready, 1);
    chk("rst_load", load, 0);       chk("rst_iter_en", iter_en, 0);
    chk("rst_done_valid", done_valid, 0); chk("rst_iter_cnt", iter_cnt, 0);
    chk("rst_sqrt_op", sqrt_op, 0); chk("rst_early_term", early_term, 0);
    chk("rst_digit_err", digit_err, 0); chk("rst_first_iter", first_iter, 0);
    next(); reset_n = 1'b1;
    next();

    // single-precision divide
    start_valid = 1'b1; sqrt = 1'b0; fmt = 2'b00;
    mid(); chk("s_load", load, 1); chk("s_ready", start_ready, 1);
    next(); start_valid = 1'b0;
    for (int c = 1; c <= 26; c++) begin
      mid();
      chk("s_iter_en", iter_en, 1);
      chk("s_iter_cnt", iter_cnt, 27 - c);
      chk("s_first_iter", first_iter, (c == 1) ? 1 : 0);
      chk("s_busy_dv", done_valid, 0);
      next();
    end
    done_ready = 1'b1;
    mid(); chk("s_done_valid", done_valid, 1); chk("s_done_iter_en", iter_en, 0);
    chk("s_done_cnt", iter_cnt, 0); chk("s_early", early_term, 0);
    next(); done_ready = 1'b0;
    mid(); chk("s_idle_busy", busy, 0); chk("s_idle_ready", start_ready, 1);
    chk("s_idle_dv", done_valid, 0);
    next();

    // quad sqrt with stalled consumer and ignored start pulses
    start_valid = 1'b1; sqrt = 1'b1; fmt = 2'b11;
    mid(); chk("q_load", load, 1);
    next(); start_valid = 1'b0; sqrt = 1'b0;
    n_it = 0; lat = 0; got = 1'b0;
    for (int c = 1; c <= 200 && !got; c++) begin
      start_valid = ((c % 7) == 3);
      mid();
      if (done_valid) begin
        got = 1'b1; lat = c;
      end else begin
        if (iter_en) n_it++;
        chk("q_no_load", load, 0);
        chk("q_sqrt_op", sqrt_op, 1);
        next();
      end
    end
    chk("q_done_reached", got, 1);
    chk("q_latency", lat, 116);
    chk("q_iter_count", n_it, 115);
    for (int k = 0; k < 5; k++) begin
      start_valid = 1'b1; #1;
      chk("q_hold_dv", done_valid, 1);
      chk("q_hold_load", load, 0);
      chk("q_hold_ready", start_ready, 0);
      chk("q_hold_sqrt", sqrt_op, 1);
      next();
      if (k < 4) mid();
    end
    start_valid = 1'b0; done_ready = 1'b1;
    mid(); chk("q_handshake_dv", done_valid, 1);
    next(); done_ready = 1'b0;
    mid(); chk("q_idle_busy", busy, 0); chk("q_idle_sqrt_held", sqrt_op, 1);
    next();

    // double divide, early termination on BUSY cycle 10; wzero in first cycle ignored
    start_valid = 1'b1; fmt = 2'b01;
    mid(); chk("d_load", load, 1);
    next(); start_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      wzero = (c == 1 || c == 10);
      mid();
      chk("d_iter_en", iter_en, (c < 10) ? 1 : 0);
      chk("d_done_valid", done_valid, 0);
      next();
    end
    wzero = 1'b0; done_ready = 1'b1;
    mid(); chk("d_done_valid11", done_valid, 1); chk("d_early_term", early_term, 1);
    chk("d_iter_cnt", iter_cnt, 46);
    next(); done_ready = 1'b0;
    mid(); chk("d_idle_busy", busy, 0); chk("d_early_held", early_term, 1);
    chk("d_cnt_held", iter_cnt, 46);
    next();

    // special case, half precision
    start_valid = 1'b1; fmt = 2'b10; special_case = 1'b1;
    mid(); chk("h_sc_load", load, 1);
    next(); start_valid = 1'b0; special_case = 1'b0; done_ready = 1'b1;
    mid(); chk("h_sc_dv", done_valid, 1); chk("h_sc_iter_en", iter_en, 0);
    chk("h_sc_early", early_term, 0); chk("h_sc_first", first_iter, 0);
    chk("h_sc_cnt", iter_cnt, 13);
    next(); done_ready = 1'b0;
    mid(); chk("h_sc_idle", busy, 0);
    next();

    // flush at BUSY cycle 5 together with wzero
    start_valid = 1'b1; fmt = 2'b00;
    next(); start_valid = 1'b0;
    for (int c = 1; c <= 4; c++) next();
    flush = 1'b1; wzero = 1'b1;
    mid(); chk("f_iter_en", iter_en, 0); chk("f_ready", start_ready, 0);
    chk("f_dv", done_valid, 0); chk("f_load", load, 0);
    next(); flush = 1'b0; wzero = 1'b0;
    mid(); chk("f_busy", busy, 0); chk("f_early", early_term, 0);
    chk("f_dv_after", done_valid, 0); chk("f_cnt_held", iter_cnt, 22);
    next();

    // flush coincident with start in IDLE
    flush = 1'b1; start_valid = 1'b1; fmt = 2'b11;
    mid(); chk("fi_load", load, 0); chk("fi_ready", start_ready, 0);
    next(); flush = 1'b0; start_valid = 1'b0;
    mid(); chk("fi_busy", busy, 0); chk("fi_cnt", iter_cnt, 22);
    next();

    // async reset mid-BUSY
    start_valid = 1'b1; sqrt = 1'b1; fmt = 2'b01;
    next(); start_valid = 1'b0; sqrt = 1'b0;
    next(); next();
    mid(); chk("r_busy_pre", busy, 1);
    reset_n = 1'b0; #1;
    chk("r_busy", busy, 0); chk("r_cnt", iter_cnt, 0); chk("r_sqrt_op", sqrt_op, 0);
    chk("r_iter_en", iter_en, 0); chk("r_ready", start_ready, 1);
    chk("r_first", first_iter, 0); chk("r_dv", done_valid, 0);
    next(); reset_n = 1'b1;
    mid(); chk("r_after_busy", busy, 0); chk("r_after_dv", done_valid, 0);
    next();

    // digit check on half-precision divide
    start_valid = 1'b1; fmt = 2'b10;
    next(); start_valid = 1'b0;
    n_it = 0;
    for (int c = 1; c <= 13; c++) begin
      uz = (c == 4);
      mid();
      if (iter_en) n_it++;
      chk("g_cnt", iter_cnt, 14 - c);
      if (c == 5) chk("g_err_set", digit_err, 1);
      next();
    end
    uz = 1'b0; done_ready = 1'b1;
    mid(); chk("g_iters", n_it, 13); chk("g_dv", done_valid, 1);
    chk("g_err_done", digit_err, 1);
    next(); done_ready = 1'b0; start_valid = 1'b1; fmt = 2'b00;
    mid(); chk("g_accept_load", load, 1); chk("g_err_still", digit_err, 1);
    next(); start_valid = 1'b0;
    mid(); chk("g_err_clear", digit_err, 0); chk("g_new_cnt", iter_cnt, 26);
    flush = 1'b1;
    next(); flush = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
